// File: rtl/player_topleft_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// player_topleft_ctrl_pkg : shared coordinate type, FSM encoding, clamp helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package player_topleft_ctrl_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CRASH   = 2'd2,
    ST_RESPAWN = 2'd3
  } state_t;

  // Two guard bits keep coord+delta free of wrap for any 11-bit coord and step.
  function automatic coord_t sat_add(input coord_t                    coord,
                                     input logic signed [COORD_W+1:0] delta,
                                     input coord_t                    lo,
                                     input coord_t                    hi);
    logic signed [COORD_W+1:0] sum;
    sum = $signed({2'b00, coord}) + delta;
    if (sum < $signed({2'b00, lo})) begin
      return lo;
    end else if (sum > $signed({2'b00, hi})) begin
      return hi;
    end else begin
      return sum[COORD_W-1:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/player_topleft_ctrl_step.sv
// ---------------------------------------------------------------------------
// coord_step_toward : moves a coordinate toward a target by step, no overshoot
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module coord_step_toward
  import player_topleft_ctrl_pkg::*;
(
  input  logic [COORD_W-1:0] cur,
  input  logic [COORD_W-1:0] target,
  input  logic [COORD_W-1:0] step,
  output logic [COORD_W-1:0] next
);

  logic signed [COORD_W+1:0] delta;
  coord_t                    lo;
  coord_t                    hi;

  always_comb begin
    delta = '0;
    lo    = cur;
    hi    = cur;
    if (cur > target) begin
      delta = -$signed({2'b00, step});
      lo    = target;
    end else if (cur < target) begin
      delta = $signed({2'b00, step});
      hi    = target;
    end
    next = sat_add(cur, delta, lo, hi);
  end

endmodule

`default_nettype wire

// File: rtl/player_topleft_ctrl.sv
// ---------------------------------------------------------------------------
// player_topleft_ctrl : per-frame player car top-left sequencer
//                       (idle / drive / crash / respawn)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module player_topleft_ctrl
  import player_topleft_ctrl_pkg::*;
#(
  parameter int unsigned INIT_X       = 304,
  parameter int unsigned INIT_Y       = 400,
  parameter int unsigned X_MIN        = 160,
  parameter int unsigned X_MAX        = 448,
  parameter int unsigned STEP_X       = 4,
  parameter int unsigned CRASH_FRAMES = 30,
  parameter int unsigned RESPAWN_STEP = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               leftKey,
  input  logic               rightKey,
  input  logic               collision,
  output logic [COORD_W-1:0] topLeftX,
  output logic [COORD_W-1:0] topLeftY,
  output logic               crashed
);

  localparam int CNT_W = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;

  localparam coord_t INIT_X_C       = COORD_W'(INIT_X);
  localparam coord_t INIT_Y_C       = COORD_W'(INIT_Y);
  localparam coord_t X_MIN_C        = COORD_W'(X_MIN);
  localparam coord_t X_MAX_C        = COORD_W'(X_MAX);
  localparam coord_t STEP_X_C       = COORD_W'(STEP_X);
  localparam coord_t RESPAWN_STEP_C = COORD_W'(RESPAWN_STEP);
  localparam logic [CNT_W-1:0] CNT_LOAD_C = CNT_W'(CRASH_FRAMES - 1);

  if (!((X_MIN <= INIT_X) && (INIT_X <= X_MAX) && (X_MAX < 2048))) begin : g_bad_range
    $error("player_topleft_ctrl: need X_MIN <= INIT_X <= X_MAX < 2048");
  end
  if ((STEP_X < 1) || (RESPAWN_STEP < 1) || (CRASH_FRAMES < 1)) begin : g_bad_step
    $error("player_topleft_ctrl: STEP_X, RESPAWN_STEP, CRASH_FRAMES must be >= 1");
  end

  state_t             state_q, state_d;
  coord_t             x_q, x_d;
  coord_t             y_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               latch_q, latch_d;
  logic               crashed_q, crashed_d;

  coord_t             step_target;
  coord_t             step_size;
  coord_t             step_next;

  // One stepper serves both the steering clamp and the respawn approach.
  coord_step_toward u_step (
    .cur    (x_q),
    .target (step_target),
    .step   (step_size),
    .next   (step_next)
  );

  always_comb begin
    step_target = INIT_X_C;
    step_size   = RESPAWN_STEP_C;
    if (state_q == ST_DRIVE) begin
      step_size = STEP_X_C;
      if (leftKey && !rightKey) begin
        step_target = X_MIN_C;
      end else if (rightKey && !leftKey) begin
        step_target = X_MAX_C;
      end else begin
        step_target = x_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;

    // A collision arriving on the tick itself is seen directly, not via latch.
    if (startOfFrame || (state_q != ST_DRIVE)) begin
      latch_d = 1'b0;
    end else begin
      latch_d = latch_q | collision;
    end

    if (startOfFrame) begin
      case (state_q)
        ST_IDLE: begin
          x_d = INIT_X_C;
          if (enable) state_d = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (!enable) begin
            state_d = ST_IDLE;
            x_d     = INIT_X_C;
          end else if (latch_q || collision) begin
            state_d = ST_CRASH;
            cnt_d   = CNT_LOAD_C;
          end else begin
            x_d = step_next;
          end
        end
        ST_CRASH: begin
          if (!enable) begin
            state_d = ST_IDLE;
            x_d     = INIT_X_C;
          end else if (cnt_q == '0) begin
            state_d = ST_RESPAWN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RESPAWN: begin
          if (!enable) begin
            state_d = ST_IDLE;
            x_d     = INIT_X_C;
          end else begin
            x_d = step_next;
            if (step_next == INIT_X_C) state_d = ST_DRIVE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          x_d     = INIT_X_C;
        end
      endcase
    end

    crashed_d = (state_d == ST_CRASH) || (state_d == ST_RESPAWN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= INIT_X_C;
      y_q       <= INIT_Y_C;
      cnt_q     <= '0;
      latch_q   <= 1'b0;
      crashed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= INIT_Y_C;
      cnt_q     <= cnt_d;
      latch_q   <= latch_d;
      crashed_q <= crashed_d;
    end
  end

  assign topLeftX = x_q;
  assign topLeftY = y_q;
  assign crashed  = crashed_q;

endmodule

`default_nettype wire

// File: tb/tb_player_topleft_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_topleft_ctrl : directed bench for the player car top-left sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_player_topleft_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        enable = 1'b0;
  logic        leftKey = 1'b0;
  logic        rightKey = 1'b0;
  logic        collision = 1'b0;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        crashed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  player_topleft_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .enable       (enable),
    .leftKey      (leftKey),
    .rightKey     (rightKey),
    .collision    (collision),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .crashed      (crashed)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame tick on one cycle; outputs sampled at the following falling edge.
  task automatic do_tick(input logic col);
    @(negedge clk);
    startOfFrame = 1'b1;
    collision    = col;
    @(negedge clk);
    startOfFrame = 1'b0;
    collision    = 1'b0;
  endtask

  task automatic pulse_collision();
    @(negedge clk);
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int exp_x;

    repeat (3) @(negedge clk);
    check("rst_x", topLeftX, 304);
    check("rst_y", topLeftY, 400);
    check("rst_crashed", crashed, 0);
    reset = 1'b0;

    // 1: enter DRIVE, steer to 360, then async reset mid-frame
    enable = 1'b1;
    do_tick(1'b0);
    check("idle_to_drive_x", topLeftX, 304);
    rightKey = 1'b1;
    repeat (14) do_tick(1'b0);
    check("drive_x_360", topLeftX, 360);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_x", topLeftX, 304);
    check("async_rst_y", topLeftY, 400);
    check("async_rst_crashed", crashed, 0);
    @(negedge clk);
    reset    = 1'b0;
    rightKey = 1'b0;
    do_tick(1'b0);
    check("rst_idle_to_drive_x", topLeftX, 304);

    // 2: right for 40 ticks, saturate at 448
    rightKey = 1'b1;
    exp_x = 304;
    for (int i = 1; i <= 40; i++) begin
      do_tick(1'b0);
      exp_x = (exp_x + 4 > 448) ? 448 : exp_x + 4;
      check("right_ramp", topLeftX, exp_x);
      if (i == 36) check("right_hits_max_36", topLeftX, 448);
    end
    leftKey = 1'b1;
    repeat (2) do_tick(1'b0);
    check("both_keys_hold", topLeftX, 448);
    check("both_keys_y", topLeftY, 400);

    // 3: left down to 164, then to 160 and stay
    rightKey = 1'b0;
    repeat (71) do_tick(1'b0);
    check("left_164", topLeftX, 164);
    exp_x = 164;
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0);
      exp_x = (exp_x - 4 < 160) ? 160 : exp_x - 4;
      check("left_clamp", topLeftX, exp_x);
    end
    check("left_stays_min", topLeftX, 160);

    // 4: up to 400, collision between ticks, crash, respawn
    leftKey  = 1'b0;
    rightKey = 1'b1;
    repeat (60) do_tick(1'b0);
    check("at_400", topLeftX, 400);
    pulse_collision();
    check("latch_not_visible", crashed, 0);
    do_tick(1'b0);
    check("crash_enter_crashed", crashed, 1);
    check("crash_enter_x", topLeftX, 400);
    // 5a: collisions during CRASH must not extend the count
    for (int i = 1; i <= 29; i++) begin
      if (i % 7 == 0) pulse_collision();
      do_tick(i == 10);
      check("crash_frozen_x", topLeftX, 400);
      check("crash_crashed", crashed, 1);
    end
    rightKey = 1'b0;
    do_tick(1'b0);
    check("respawn_enter_x", topLeftX, 400);
    check("respawn_enter_crashed", crashed, 1);
    exp_x = 400;
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) pulse_collision();
      do_tick(i == 5);
      exp_x = (exp_x - 8 < 304) ? 304 : exp_x - 8;
      check("respawn_x", topLeftX, exp_x);
      check("respawn_crashed", crashed, (exp_x != 304) ? 1 : 0);
    end
    rightKey = 1'b1;
    do_tick(1'b0);
    check("back_in_drive_x", topLeftX, 308);
    check("back_in_drive_crashed", crashed, 0);

    // 5b: collision on the tick cycle itself
    do_tick(1'b1);
    check("tick_collision_crashed", crashed, 1);
    check("tick_collision_x", topLeftX, 308);

    // 6: drop enable during CRASH
    rightKey = 1'b0;
    do_tick(1'b0);
    enable = 1'b0;
    do_tick(1'b0);
    check("disable_x", topLeftX, 304);
    check("disable_crashed", crashed, 0);
    do_tick(1'b0);
    check("idle_hold_x", topLeftX, 304);
    enable = 1'b1;
    pulse_collision();
    do_tick(1'b0);
    check("reenable_x", topLeftX, 304);
    check("reenable_crashed", crashed, 0);
    rightKey = 1'b1;
    do_tick(1'b0);
    check("reenable_drive_x", topLeftX, 308);
    check("idle_collision_ignored", crashed, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
